pipe_stage_skid: RTL and testbench

- Parametrised pipeline stage register; the generalised successor of the fixed 32-bit PC/instruction stage latches between CPU pipeline stages.
- Payload is an arbitrary-width bus (callers concatenate PC, instruction, control).
- Adds valid/ready handshake, a 2-entry skid buffer so `in_ready_o` is registered, a stall override, and flush-to-bubble with a programmable NOP value.
- Instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/pipe_stage_skid_if.sv | 22 ++
 rtl/pipe_stage_skid.sv | 115 +++++++++++
 tb/tb_pipe_stage_skid.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready payload bus between pipeline stages
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  // slave: the stage itself; master: the environment driving it
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - pipeline stage with 2-entry skid buffer, stall and flush-to-NOP
// PIPE_STAGE_PERF_EN adds saturating stall/flush counters.
module pipe_stage_skid #(
  parameter int                 DATA_W  = 64,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0,
  parameter int                 CNT_W   = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic                  stall_i,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
`endif
  pipe_stage_skid_if.slave      bus
);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready;
  logic              out_valid;
  logic              acc;
  logic              rdy;
  logic              dep;

  // in_ready depends only on the skid flag so the upstream path is registered
  assign in_ready        = start_i & ~s_valid_q;
  assign out_valid       = start_i & m_valid_q;
  assign acc             = bus.in_valid_i & in_ready;
  assign rdy             = bus.out_ready_i & ~stall_i;
  assign dep             = out_valid & rdy;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = m_data_q;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (start_i) begin
      if (flush_i) begin
        m_valid_d = 1'b0;
        s_valid_d = 1'b0;
        m_data_d  = NOP_VAL;
      end else if (!m_valid_q) begin
        if (acc) begin
          m_valid_d = 1'b1;
          m_data_d  = bus.in_data_i;
        end
      end else if (dep) begin
        if (s_valid_q) begin
          m_data_d  = s_data_q;
          s_valid_d = 1'b0;
        end else if (acc) begin
          m_data_d  = bus.in_data_i;
        end else begin
          m_valid_d = 1'b0;
          m_data_d  = NOP_VAL;
        end
      end else if (acc) begin
        s_valid_d = 1'b1;
        s_data_d  = bus.in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_data_q  <= NOP_VAL;
      s_data_q  <= NOP_VAL;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_data_q  <= m_data_d;
      s_data_q  <= s_data_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // counters stick at all-ones rather than wrapping
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (start_i && m_valid_q && !rdy && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (start_i && flush_i && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed self-checking bench for pipe_stage_skid
module tb_pipe_stage_skid;
  localparam int              DW  = 16;
  localparam logic [DW-1:0]   NOP = 16'hDEAD;
  localparam int              CW  = 4;

  logic clk;
  logic rst;
  logic start;
  logic flush;
  logic stall;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] flush_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_stage_skid_if #(.DATA_W(DW)) bus ();

  pipe_stage_skid #(
    .DATA_W  (DW),
    .NOP_VAL (NOP),
    .CNT_W   (CW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .flush_i     (flush),
    .stall_i     (stall),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt),
`endif
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [DW-1:0] d);
    check({tag, "_valid"}, 64'(bus.out_valid_o), 64'(v));
    check({tag, "_data"},  64'(bus.out_data_o),  64'(d));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; stall = 1'b0;
    bus.in_valid_i = 1'b0; bus.in_data_i = '0; bus.out_ready_i = 1'b0;

    // reset state
    tick();
    expect_out("rst", 1'b0, NOP);
    check("rst_in_ready_nostart", 64'(bus.in_ready_o), 64'd0);
    start = 1'b1; #1;
    check("rst_in_ready_start", 64'(bus.in_ready_o), 64'd1);
`ifdef PIPE_STAGE_PERF_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt), 64'd0);
`endif

    // single-cycle latency, then back-to-back stream
    rst = 1'b0;
    bus.in_valid_i = 1'b1; bus.in_data_i = 16'h1234; bus.out_ready_i = 1'b1;
    tick();
    expect_out("first", 1'b1, 16'h1234);
    for (int i = 1; i <= 8; i++) begin
      bus.in_data_i = DW'(i);
      tick();
      expect_out($sformatf("stream%0d", i), 1'b1, DW'(i));
      check($sformatf("stream%0d_rdy", i), 64'(bus.in_ready_o), 64'd1);
    end
    bus.in_valid_i = 1'b0;
    tick();
    expect_out("drain", 1'b0, NOP);

    // stall fills skid, release drains in order
    bus.in_valid_i = 1'b1; bus.in_data_i = 16'h00A0;
    tick();
    stall = 1'b1; bus.in_data_i = 16'h00B0;
    tick();
    expect_out("stallB", 1'b1, 16'h00A0);
    check("stallB_rdy", 64'(bus.in_ready_o), 64'd0);
    bus.in_data_i = 16'h00C0;
    tick();
    expect_out("stallC", 1'b1, 16'h00A0);
    check("stallC_rdy", 64'(bus.in_ready_o), 64'd0);
    stall = 1'b0;
    tick();
    expect_out("relB", 1'b1, 16'h00B0);
    check("relB_rdy", 64'(bus.in_ready_o), 64'd1);
    tick();
    expect_out("relC", 1'b1, 16'h00C0);
    bus.in_valid_i = 1'b0;
    tick();
    expect_out("relEmpty", 1'b0, NOP);

    // flush while full with D presented
    stall = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = 16'h00A1;
    tick();
    bus.in_data_i = 16'h00B1;
    tick();
    flush = 1'b1; bus.in_data_i = 16'h00D1;
    tick();
    expect_out("flushFull", 1'b0, NOP);
    check("flushFull_rdy", 64'(bus.in_ready_o), 64'd1);
    flush = 1'b0; stall = 1'b0; bus.in_valid_i = 1'b0;
    tick();
    expect_out("flushFull_lost", 1'b0, NOP);

    // flush wins over an accepted input while main held and stalled
    stall = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = 16'h00A2;
    tick();
    flush = 1'b1; bus.in_data_i = 16'h00D2;
    tick();
    expect_out("flushAcc", 1'b0, NOP);
    flush = 1'b0; bus.in_valid_i = 1'b0; stall = 1'b0;
    tick();
    expect_out("flushAcc_lost", 1'b0, NOP);

    // start low freezes a full stage
    stall = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = 16'h00A3;
    tick();
    bus.in_data_i = 16'h00B3;
    tick();
    start = 1'b0; stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.out_ready_i = i[0];
      bus.in_valid_i  = ~i[0];
      flush           = i[1];
      bus.in_data_i   = 16'hEE00 + DW'(i);
      tick();
      check($sformatf("frz%0d_valid", i), 64'(bus.out_valid_o), 64'd0);
      check($sformatf("frz%0d_rdy", i), 64'(bus.in_ready_o), 64'd0);
    end
    start = 1'b1; flush = 1'b0; stall = 1'b1; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    #1;
    expect_out("thawA", 1'b1, 16'h00A3);
    check("thaw_rdy", 64'(bus.in_ready_o), 64'd0);
    stall = 1'b0;
    tick();
    expect_out("thawB", 1'b1, 16'h00B3);
    tick();
    expect_out("thawEmpty", 1'b0, NOP);

    // reset while full and stalled
    stall = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = 16'h00A4;
    tick();
    bus.in_data_i = 16'h00B4;
    tick();
    rst = 1'b1; bus.in_valid_i = 1'b0;
    tick();
    expect_out("rstFull", 1'b0, NOP);
    check("rstFull_rdy", 64'(bus.in_ready_o), 64'd1);
    rst = 1'b0; stall = 1'b0;

`ifdef PIPE_STAGE_PERF_EN
    // counters start from a fresh reset and saturate
    rst = 1'b1;
    tick();
    rst = 1'b0; stall = 1'b1; bus.in_valid_i = 1'b1; bus.in_data_i = 16'h00A5;
    tick();
    bus.in_valid_i = 1'b0;
    check("perf_stall0", 64'(stall_cnt), 64'd0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 3) check("perf_stall3", 64'(stall_cnt), 64'd3);
    end
    check("perf_stall_sat", 64'(stall_cnt), 64'd15);
    stall = 1'b0; flush = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    flush = 1'b0;
    tick();
    check("perf_flush3", 64'(flush_cnt), 64'd3);
    check("perf_stall_hold", 64'(stall_cnt), 64'd15);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
